mul16_bam_v4h0: RTL and testbench
=================================

Name: mul16_bam_v4h0

Overview:
- Registered 16x16 unsigned approximate multiplier using a Broken Array Multiplier (BAM) with vertical break level VBL=4 and horizontal break level HBL=0.
- Every partial-product bit whose weight is below 2^4 is omitted; all other partial-product bits are summed exactly.
- Serves as a low-power approximate multiplier leaf in the error-tolerant datapath, and as a golden-model target for vector-file comparison.

Parameters:
- None exposed. Widths (16-bit operands, 32-bit product), VBL=4 and HBL=0 are fixed constants.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operands a/b valid this cycle
- a  input  16  unsigned multiplicand
- b  input  16  unsigned multiplier
- c  output  32  unsigned approximate product, registered
- out_valid  output  1  c holds the result of an accepted operand pair

Behaviour:
- Partial products: pp[i][j] = a[i] & b[j], weight 2^(i+j), with i,j in 0..15.
- BAM rule with VBL=4: drop pp[i][j] whenever i+j < 4. These are the 10 bits in columns 0..3.
- BAM rule with HBL=0: no rows are dropped.
- Result: c = sum over i+j >= 4 of pp[i][j]·2^(i+j). Equivalently, c = a·b − E, where E = sum over i+j < 4 of pp[i][j]·2^(i+j).
- Error bounds: 0 <= E <= 49. c[3:0] is always 0. c never exceeds 32 bits and never underflows.
- Summation of retained bits must be exact. Any internal adder tree or carry-save arrangement is allowed provided results are bit-identical to the formula.
- Timing: on each rising clk edge with rst_n=1:
  - c <= f(a,b) when in_valid=1; otherwise c holds its previous value.
  - out_valid <= in_valid.
  - Latency is exactly 1 cycle; throughput is one result per cycle.
- Reset: at a rising edge with rst_n=0, c <= 0 and out_valid <= 0, regardless of in_valid. A reset asserted mid-stream discards the in-flight operation. The first result after reset release appears one cycle after the first in_valid=1.
- No combinational path from a, b or in_valid to any output.
- Determinism: identical operands always give identical c. Operand order is irrelevant: f(a,b) = f(b,a).

Decomposition:
- Package mul_bam_pkg:
  - OP_W = 16, PROD_W = 32, BAM_VBL = 4, BAM_HBL = 0.
  - A function returning the BAM reference value, shared with the bench scoreboard.
- One natural sub-module, bam_array_16x16: purely combinational.
  - Generates the retained partial-product bits and reduces them, e.g. a carry-save rows array with a final ripple/CPA adder.
  - Produces the 32-bit sum.
- Top level holds only the input-valid gating and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with in_valid=1, a=b=65535 -> c=0 and out_valid=0. Then release rst_n, apply a=b=65535 -> one cycle later c=4294836176 (0xFFFDFFD0, exact minus 49), out_valid=1.
- Low-weight truncation:
  - a=1,b=1 -> c=0
  - a=3,b=3 -> c=0
  - a=15,b=15 -> c=176 (exact 225, E=49)
  - a=0,b=12345 -> c=0
- Exact when no low-column terms exist:
  - a=16,b=3 -> c=48
  - a=1000,b=1000 -> c=1000000
  - a=65535,b=16 -> c=1048560
- Pipeline/valid:
  - Back-to-back pairs (15,15), (16,3), (1000,1000) on consecutive cycles -> c=176, 48, 1000000 on the following three cycles with out_valid high.
  - Then in_valid=0 -> c holds 1000000 and out_valid=0.
- Mid-stream reset: assert rst_n=0 for one edge while in_valid=1, a=b=15 -> c=0 and out_valid=0 on that edge. The next accepted pair produces its correct value.
- Random regression: at least 1000 random (a,b) pairs plus the corners 0, 1, 15, 16, 0x8000 and 0xFFFF -> c equals the package reference function. Also check c[3:0]==0 and 0 <= a·b − c <= 49 for every vector.

Source files
------------

// File: rtl/mul16_bam_v4h0_pkg.sv
// Shared constants and helpers for the 16x16 broken-array multiplier.
// Provides the operand and product widths, the break levels, and the retained-bit
// mask per row. Also provides a bit-level reference function used by the scoreboard.
package mul_bam_pkg;

    localparam int unsigned OP_W    = 16;
    localparam int unsigned PROD_W  = 32;
    localparam int unsigned BAM_VBL = 4;
    localparam int unsigned BAM_HBL = 0;

    // Multiplicand bits kept in row `row` (b bit index): a[i] survives when i+row >= VBL.
    function automatic logic [OP_W-1:0] keep_mask(input int unsigned row);
        logic [OP_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            m[i] = ((i + row) >= BAM_VBL);
        end
        return m;
    endfunction

    // Reference BAM product: sum of every retained partial-product bit.
    function automatic logic [PROD_W-1:0] bam_ref(input logic [OP_W-1:0] a,
                                                  input logic [OP_W-1:0] b);
        logic [PROD_W-1:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            for (int unsigned j = 0; j < OP_W; j++) begin
                if (((i + j) >= BAM_VBL) && a[i] && b[j]) begin
                    acc = acc + (PROD_W'(1) << (i + j));
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/mul16_bam_v4h0_if.sv
// Operand/result bus of the BAM multiplier.
//   in_valid, a, b : operand pair, driven by the master
//   c, out_valid   : registered product and its valid, driven by the slave
interface mul16_bam_v4h0_if;
    import mul_bam_pkg::*;

    logic              in_valid;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic [PROD_W-1:0] c;
    logic              out_valid;

    modport master (output in_valid, output a, output b, input c, input out_valid);
    modport slave  (input in_valid, input a, input b, output c, output out_valid);
endinterface

// File: rtl/mul16_bam_v4h0_array.sv
// Combinational broken-array core: builds the retained partial-product rows
// and reduces them with a carry-save chain, then a final carry-propagate add.
//   a, b : unsigned operands
//   sum_c: approximate product (columns below VBL omitted)
module bam_array_16x16
    import mul_bam_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] sum_c
);

    logic [PROD_W-1:0] rows [OP_W];
    logic [PROD_W-1:0] cs_sum;
    logic [PROD_W-1:0] cs_carry;

    // One shifted row per multiplier bit, low-weight bits masked away.
    always_comb begin
        for (int unsigned j = 0; j < OP_W; j++) begin
            rows[j] = b[j] ? (PROD_W'(a & keep_mask(j)) << j) : '0;
        end
    end

    // 3:2 compression of each row into the running sum/carry pair.
    // Carries past bit 31 are dropped; the true sum always fits in 32 bits.
    always_comb begin
        logic [PROD_W-1:0] s;
        logic [PROD_W-1:0] k;
        logic [PROD_W-1:0] t;
        s = '0;
        k = '0;
        for (int unsigned j = 0; j < OP_W; j++) begin
            t = s ^ k ^ rows[j];
            k = ((s & k) | (s & rows[j]) | (k & rows[j])) << 1;
            s = t;
        end
        cs_sum   = s;
        cs_carry = k;
    end

    assign sum_c = cs_sum + cs_carry;

endmodule

// File: rtl/mul16_bam_v4h0.sv
// Registered 16x16 BAM approximate multiplier (VBL=4, HBL=0), 1-cycle latency.
//   clk, rst_n : clock and synchronous active-low reset
//   bus        : operand pair in (in_valid, a, b), registered result out (c, out_valid)
module mul16_bam_v4h0
    import mul_bam_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    mul16_bam_v4h0_if.slave    bus
);

    logic [PROD_W-1:0] prod_c;

    bam_array_16x16 u_array (
        .a     (bus.a),
        .b     (bus.b),
        .sum_c (prod_c)
    );

    // Output registers: result captured only for accepted pairs, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.c         <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.c <= prod_c;
            end
        end
    end

endmodule

// File: tb/tb_mul16_bam_v4h0.sv
// Bench for mul16_bam_v4h0: directed literal checks plus a cycle-by-cycle
// scoreboard driven by a behavioural model (exact product minus low-column error).
module tb_mul16_bam_v4h0;
    import mul_bam_pkg::*;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    bit   en;

    mul16_bam_v4h0_if bus ();

    mul16_bam_v4h0 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: a*b minus the partial products lying in columns 0..3.
    function automatic logic [31:0] model(input logic [15:0] x, input logic [15:0] y);
        longint unsigned exact;
        longint unsigned e;
        exact = longint'(x) * longint'(y);
        e = 0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j + i < 4; j++) begin
                if (x[i] && y[j]) e += longint'(1) << (i + j);
            end
        end
        return 32'(exact - e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Scoreboard: model state advanced on every edge, DUT compared 1 time unit later.
    logic [31:0] exp_c;
    logic        exp_v;
    logic [15:0] la, lb;
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_c = '0;
            exp_v = 1'b0;
        end else begin
            exp_v = bus.in_valid;
            if (bus.in_valid) begin
                exp_c = model(bus.a, bus.b);
                la    = bus.a;
                lb    = bus.b;
            end
        end
        #1;
        if (en) begin
            chk("sb_c", bus.c, exp_c);
            chk("sb_out_valid", 32'(bus.out_valid), 32'(exp_v));
            if (exp_v) begin
                longint unsigned p;
                longint unsigned d;
                p = longint'(la) * longint'(lb);
                d = p - longint'(bus.c);
                chk("sb_low_nibble", 32'(bus.c[3:0]), 32'd0);
                chk("sb_err_bound", 32'((longint'(bus.c) <= p) && (d <= 49)), 32'd1);
                chk("sb_pkg_ref", bus.c, bam_ref(la, lb));
            end
        end
    end

    // Drive one accepted pair and return the DUT result after the capturing edge.
    task automatic apply(input logic [15:0] x, input logic [15:0] y, output logic [31:0] res);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = x;
        bus.b        = y;
        @(posedge clk);
        #2;
        res = bus.c;
    endtask

    typedef struct { logic [15:0] x; logic [15:0] y; logic [31:0] r; } vec_t;
    vec_t dir [7];
    logic [15:0] corners [6];

    initial begin
        logic [31:0] r;
        errors = 0;
        checks = 0;
        en     = 1'b0;

        // Pin the model itself against hand-computed values.
        chk("model_15x15", model(16'd15, 16'd15), 32'd176);
        chk("model_ffff", model(16'hFFFF, 16'hFFFF), 32'hFFFDFFD0);
        chk("model_3x3", model(16'd3, 16'd3), 32'd0);

        // Reset held for two edges with a valid max-operand pair present.
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_c", bus.c, 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        chk("first_ffff", bus.c, 32'd4294836176);
        chk("first_out_valid", 32'(bus.out_valid), 32'd1);

        dir[0] = '{16'd1,     16'd1,     32'd0};
        dir[1] = '{16'd3,     16'd3,     32'd0};
        dir[2] = '{16'd15,    16'd15,    32'd176};
        dir[3] = '{16'd0,     16'd12345, 32'd0};
        dir[4] = '{16'd16,    16'd3,     32'd48};
        dir[5] = '{16'd1000,  16'd1000,  32'd1000000};
        dir[6] = '{16'd65535, 16'd16,    32'd1048560};
        foreach (dir[k]) begin
            apply(dir[k].x, dir[k].y, r);
            chk($sformatf("dir_%0dx%0d", dir[k].x, dir[k].y), r, dir[k].r);
        end

        // Back-to-back pairs, then an idle cycle.
        apply(16'd15, 16'd15, r);     chk("b2b_0", r, 32'd176);
        apply(16'd16, 16'd3, r);      chk("b2b_1", r, 32'd48);
        apply(16'd1000, 16'd1000, r); chk("b2b_2", r, 32'd1000000);
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2;
        chk("idle_hold_c", bus.c, 32'd1000000);
        chk("idle_out_valid", 32'(bus.out_valid), 32'd0);

        // Mid-stream reset discards the in-flight pair.
        @(negedge clk);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.a        = 16'd15;
        bus.b        = 16'd15;
        @(posedge clk);
        #2;
        chk("midrst_c", bus.c, 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply(16'd16, 16'd3, r);
        chk("post_midrst", r, 32'd48);

        // Corner cross-product.
        corners = '{16'd0, 16'd1, 16'd15, 16'd16, 16'h8000, 16'hFFFF};
        foreach (corners[i]) begin
            foreach (corners[j]) begin
                apply(corners[i], corners[j], r);
            end
        end

        // Random traffic with occasional idle cycles.
        for (int n = 0; n < 1200; n++) begin
            @(negedge clk);
            bus.in_valid = ($urandom_range(0, 7) != 0);
            bus.a        = 16'($urandom);
            bus.b        = 16'($urandom);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
